// File: rtl/i2c_target_pkg.sv
// Shared types and constants for the i2c_target_regs register-mapped I2C responder.
package i2c_target_pkg;

   typedef enum logic [3:0] {
      IDLE,
      ADDR,
      ADDR_ACK,
      PTR,
      PTR_ACK,
      WDATA,
      WACK,
      READ,
      MACK,
      WAIT_STOP
   } i2c_state_e;

   localparam logic I2C_RD = 1'b1;
   localparam logic I2C_WR = 1'b0;

endpackage

// File: rtl/i2c_target_regs_if.sv
// Byte register port between the I2C responder (master side) and its register file (slave side).
interface i2c_target_regs_if;

   logic [7:0] o_reg_addr;
   logic [7:0] i_reg_rdata;
   logic [7:0] o_reg_wdata;
   logic       o_reg_wstrobe;
   logic       o_reg_rstrobe;

   modport master (
      output o_reg_addr,
      output o_reg_wdata,
      output o_reg_wstrobe,
      output o_reg_rstrobe,
      input  i_reg_rdata
   );

   modport slave (
      input  o_reg_addr,
      input  o_reg_wdata,
      input  o_reg_wstrobe,
      input  o_reg_rstrobe,
      output i_reg_rdata
   );

endinterface

// File: rtl/i2c_line_filter.sv
// Two-flop synchronizer, optional glitch filter (I2C_TARGET_GLITCH_FILTER_EN) and edge detect
// for one open-drain bus line.
module i2c_line_filter #(
   parameter int unsigned FILTER_CLKS = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic din,
   output logic dout,
   output logic rise,
   output logic fall
);

`ifdef I2C_TARGET_GLITCH_FILTER_EN
   localparam bit UseFilter = 1'b1;
`else
   localparam bit UseFilter = 1'b0;
`endif

   logic [1:0] sync;
   logic       prev;

   // Lines idle high, so reset to 1 to avoid a spurious edge on release.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) sync <= '1;
      else       sync <= {sync[0], din};
   end

   if (UseFilter && FILTER_CLKS > 1) begin : g_filter
      localparam int unsigned CW = $clog2(FILTER_CLKS);
      logic [CW-1:0] cnt;
      logic          filt;

      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            cnt  <= '0;
            filt <= 1'b1;
         end else if (sync[1] == filt) begin
            cnt <= '0;
         end else if (cnt == CW'(FILTER_CLKS - 1)) begin
            filt <= sync[1];
            cnt  <= '0;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end

      assign dout = filt;
   end else begin : g_direct
      assign dout = sync[1];
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) prev <= 1'b1;
      else       prev <= dout;
   end

   assign rise = dout & ~prev;
   assign fall = ~dout & prev;

endmodule

// File: rtl/i2c_target_regs.sv
// I2C target mapping bus traffic onto an 8-bit-addressed byte register port with an
// auto-incrementing pointer. Optional input glitch filter: I2C_TARGET_GLITCH_FILTER_EN.
module i2c_target_regs
   import i2c_target_pkg::*;
#(
   parameter logic [6:0]  DEV_ADDR    = 7'h55,
   parameter int unsigned FILTER_CLKS = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             scl_i,
   input  logic             sda_i,
   output logic             sda_oe,
   output logic             o_busy,
   i2c_target_regs_if.master regs
);

   logic scl_s, scl_rise, scl_fall;
   logic sda_s, sda_rise, sda_fall;

   i2c_line_filter #(.FILTER_CLKS(FILTER_CLKS)) u_scl_filter (
      .clk  (clk),
      .reset(reset),
      .din  (scl_i),
      .dout (scl_s),
      .rise (scl_rise),
      .fall (scl_fall)
   );

   i2c_line_filter #(.FILTER_CLKS(FILTER_CLKS)) u_sda_filter (
      .clk  (clk),
      .reset(reset),
      .din  (sda_i),
      .dout (sda_s),
      .rise (sda_rise),
      .fall (sda_fall)
   );

   logic       start_ev, stop_ev;
   i2c_state_e state;
   logic [2:0] bit_cnt;
   logic [6:0] shreg;
   logic [7:0] rx_byte;
   logic       rw, load_pend;
   logic [7:0] reg_addr, reg_wdata;
   logic       wstrobe, rstrobe;

   // An SCL edge in the same cycle masks any START/STOP.
   assign start_ev = sda_fall & scl_s & ~(scl_rise | scl_fall);
   assign stop_ev  = sda_rise & scl_s & ~(scl_rise | scl_fall);
   assign rx_byte  = {shreg, sda_s};
   assign rstrobe  = (state == READ) & load_pend & scl_fall;

   assign regs.o_reg_addr    = reg_addr;
   assign regs.o_reg_wdata   = reg_wdata;
   assign regs.o_reg_wstrobe = wstrobe;
   assign regs.o_reg_rstrobe = rstrobe;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         bit_cnt   <= '0;
         shreg     <= '0;
         rw        <= 1'b0;
         load_pend <= 1'b0;
         reg_addr  <= '0;
         reg_wdata <= '0;
         wstrobe   <= 1'b0;
         sda_oe    <= 1'b0;
         o_busy    <= 1'b0;
      end else begin
         wstrobe <= 1'b0;
         if (wstrobe) reg_addr <= reg_addr + 8'd1;

         if (stop_ev) begin
            state     <= IDLE;
            sda_oe    <= 1'b0;
            o_busy    <= 1'b0;
            load_pend <= 1'b0;
         end else if (start_ev) begin
            state     <= ADDR;
            bit_cnt   <= '0;
            sda_oe    <= 1'b0;
            load_pend <= 1'b0;
         end else begin
            case (state)
               ADDR, PTR, WDATA: begin
                  if (scl_rise) begin
                     shreg   <= rx_byte[6:0];
                     bit_cnt <= bit_cnt + 3'd1;
                     if (bit_cnt == 3'd7) begin
                        if (state == ADDR) begin
                           if (rx_byte[7:1] == DEV_ADDR) begin
                              state  <= ADDR_ACK;
                              rw     <= rx_byte[0];
                              o_busy <= 1'b1;
                           end else begin
                              state  <= WAIT_STOP;
                              o_busy <= 1'b0;
                           end
                        end else if (state == PTR) begin
                           reg_addr <= rx_byte;
                           state    <= PTR_ACK;
                        end else begin
                           reg_wdata <= rx_byte;
                           wstrobe   <= 1'b1;
                           state     <= WACK;
                        end
                     end
                  end
               end
               // sda_oe doubles as the ACK phase marker: first fall drives, second releases.
               // Reads leave on the ACK-clock rise so READ captures on the closing fall.
               ADDR_ACK, PTR_ACK, WACK: begin
                  if (scl_fall) begin
                     if (!sda_oe) begin
                        sda_oe <= 1'b1;
                     end else begin
                        sda_oe <= 1'b0;
                        state  <= (state == ADDR_ACK && rw == I2C_WR) ? PTR : WDATA;
                     end
                  end else if (scl_rise && sda_oe && state == ADDR_ACK && rw == I2C_RD) begin
                     state     <= READ;
                     load_pend <= 1'b1;
                  end
               end
               READ: begin
                  if (scl_fall) begin
                     if (load_pend) begin
                        shreg     <= regs.i_reg_rdata[6:0];
                        sda_oe    <= ~regs.i_reg_rdata[7];
                        reg_addr  <= reg_addr + 8'd1;
                        load_pend <= 1'b0;
                        bit_cnt   <= '0;
                     end else if (bit_cnt == 3'd7) begin
                        sda_oe  <= 1'b0;
                        state   <= MACK;
                        bit_cnt <= '0;
                     end else begin
                        sda_oe  <= ~shreg[6];
                        shreg   <= {shreg[5:0], 1'b0};
                        bit_cnt <= bit_cnt + 3'd1;
                     end
                  end
               end
               MACK: begin
                  if (scl_rise) begin
                     if (sda_s) begin
                        state  <= WAIT_STOP;
                        o_busy <= 1'b0;
                     end else begin
                        state     <= READ;
                        load_pend <= 1'b1;
                     end
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_i2c_target_regs.sv
// Bit-banged I2C initiator with a reference register model and a strobe scoreboard
// for i2c_target_regs.
module tb_i2c_target_regs;
   import i2c_target_pkg::*;

   localparam logic [6:0] DEV = 7'h55;
   localparam int         Q   = 10;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic scl_m = 1'b1;
   logic sda_m = 1'b1;
   logic scl_i, sda_i, sda_oe, o_busy;

   i2c_target_regs_if regs();

   assign scl_i = scl_m;
   assign sda_i = sda_m & ~sda_oe;

   i2c_target_regs #(.DEV_ADDR(DEV), .FILTER_CLKS(4)) dut (
      .clk   (clk),
      .reset (reset),
      .scl_i (scl_i),
      .sda_i (sda_i),
      .sda_oe(sda_oe),
      .o_busy(o_busy),
      .regs  (regs)
   );

   always #5 clk = ~clk;

   // Register file behind the port: reset image is addr+0x10.
   logic [7:0] rf [256];
   assign regs.i_reg_rdata = rf[regs.o_reg_addr];
   always @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < 256; i++) rf[i] <= 8'(i + 16);
      end else if (regs.o_reg_wstrobe) begin
         rf[regs.o_reg_addr] <= regs.o_reg_wdata;
      end
   end

   // Reference model
   logic [7:0] ref_mem [256];
   logic [7:0] ref_ptr;

   typedef struct packed {
      logic [7:0] addr;
      logic [7:0] data;
   } wr_t;
   wr_t        exp_wq[$];
   logic [7:0] exp_rq[$];

   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 256; i++) ref_mem[i] = 8'(i + 16);
      ref_ptr = 8'h00;
   endtask

   // Scoreboard monitor
   always @(negedge clk) begin
      if (!reset) begin
         if (regs.o_reg_wstrobe) begin
            if (exp_wq.size() == 0) begin
               total++; bad++;
               $display("FAIL wstrobe_unexpected actual=addr %0h data %0h required=none",
                        regs.o_reg_addr, regs.o_reg_wdata);
            end else begin
               wr_t w;
               w = exp_wq.pop_front();
               check("wstrobe_addr_data", {regs.o_reg_addr, regs.o_reg_wdata}, {w.addr, w.data});
            end
         end
         if (regs.o_reg_rstrobe) begin
            if (exp_rq.size() == 0) begin
               total++; bad++;
               $display("FAIL rstrobe_unexpected actual=addr %0h required=none", regs.o_reg_addr);
            end else begin
               check("rstrobe_addr", regs.o_reg_addr, exp_rq.pop_front());
            end
         end
      end
   end

   task automatic wait_clks(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic bit_xfer(input logic b, output logic line);
      wait_clks(Q); sda_m = b;
      wait_clks(Q); scl_m = 1'b1;
      wait_clks(Q); line = sda_i;
      wait_clks(Q); scl_m = 1'b0;
   endtask

   task automatic i2c_start();
      wait_clks(Q); sda_m = 1'b1;
      wait_clks(Q); scl_m = 1'b1;
      wait_clks(Q); sda_m = 1'b0;
      wait_clks(Q); scl_m = 1'b0;
   endtask

   task automatic i2c_stop();
      wait_clks(Q); sda_m = 1'b0;
      wait_clks(Q); scl_m = 1'b1;
      wait_clks(Q); sda_m = 1'b1;
      wait_clks(Q);
   endtask

   task automatic write_byte(input logic [7:0] b, output logic ack);
      logic line;
      for (int i = 7; i >= 0; i--) bit_xfer(b[i], line);
      bit_xfer(1'b1, line);
      ack = ~line;
   endtask

   task automatic read_byte(input logic master_ack, output logic [7:0] d);
      logic line;
      for (int i = 7; i >= 0; i--) begin
         bit_xfer(1'b1, line);
         d[i] = line;
      end
      bit_xfer(~master_ack, line);
   endtask

   task automatic tx_write(input logic [7:0] ptr, input logic [7:0] data[$]);
      logic ack;
      wr_t  w;
      i2c_start();
      write_byte({DEV, I2C_WR}, ack);
      check("addr_w_ack", ack, 1);
      check("busy_after_match", o_busy, 1);
      write_byte(ptr, ack);
      check("ptr_ack", ack, 1);
      ref_ptr = ptr;
      foreach (data[k]) begin
         w.addr = ref_ptr; w.data = data[k];
         exp_wq.push_back(w);
         ref_mem[ref_ptr] = data[k];
         ref_ptr = ref_ptr + 8'd1;
         write_byte(data[k], ack);
         check("data_ack", ack, 1);
      end
      i2c_stop();
      wait_clks(4);
      check("busy_after_stop", o_busy, 0);
      check("ptr_after_write", regs.o_reg_addr, ref_ptr);
   endtask

   task automatic tx_read(input bit set_ptr, input logic [7:0] ptr, input int n);
      logic       ack;
      logic [7:0] d;
      i2c_start();
      if (set_ptr) begin
         write_byte({DEV, I2C_WR}, ack);
         check("addr_w_ack", ack, 1);
         write_byte(ptr, ack);
         check("ptr_ack", ack, 1);
         ref_ptr = ptr;
         i2c_start();
      end
      for (int k = 0; k < n; k++) exp_rq.push_back(8'(ref_ptr + 8'(k)));
      write_byte({DEV, I2C_RD}, ack);
      check("addr_r_ack", ack, 1);
      check("busy_in_read", o_busy, 1);
      for (int k = 0; k < n; k++) begin
         read_byte(k != n - 1, d);
         check("read_byte", d, ref_mem[ref_ptr]);
         ref_ptr = ref_ptr + 8'd1;
      end
      check("sda_released_after_nack", sda_oe, 0);
      check("busy_after_nack", o_busy, 0);
      i2c_stop();
      wait_clks(4);
      check("ptr_after_read", regs.o_reg_addr, ref_ptr);
   endtask

   initial begin
      #3ms;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic       ack, line;
      logic [7:0] q[$];
      model_reset();
      wait_clks(5);
      check("rst_sda_oe", sda_oe, 0);
      check("rst_busy", o_busy, 0);
      check("rst_addr", regs.o_reg_addr, 0);
      check("rst_wdata", regs.o_reg_wdata, 0);
      check("rst_strobes", {regs.o_reg_wstrobe, regs.o_reg_rstrobe}, 0);
      reset = 1'b0;
      wait_clks(5);

      // Pointer write, repeated start, 4-byte read
      tx_read(1'b1, 8'h07, 4);

      // Pointer write then single-byte write
      q = '{8'h5C};
      tx_write(8'h07, q);

      // Wrong address: no ACK, no strobes
      i2c_start();
      write_byte(8'hE0, ack);
      check("wrong_addr_nack", ack, 0);
      check("wrong_addr_busy", o_busy, 0);
      write_byte(8'h12, ack);
      check("wait_stop_nack", ack, 0);
      i2c_stop();
      wait_clks(4);
      check("wrong_addr_ptr", regs.o_reg_addr, ref_ptr);

      // Pointer wrap
      q = '{8'h11, 8'h22};
      tx_write(8'hFF, q);
      tx_read(1'b0, 8'h00, 1);

      // Abort mid-byte with repeated start
      i2c_start();
      write_byte({DEV, I2C_WR}, ack);
      check("abort_addr_ack", ack, 1);
      write_byte(8'h40, ack);
      check("abort_ptr_ack", ack, 1);
      for (int i = 0; i < 5; i++) bit_xfer(1'($urandom_range(0, 1)), line);
      i2c_start();
      check("abort_busy_held", o_busy, 1);
      q = '{8'hC3};
      begin
         wr_t w;
         write_byte({DEV, I2C_WR}, ack);
         check("abort_readdr_ack", ack, 1);
         write_byte(8'h41, ack);
         check("abort_ptr2_ack", ack, 1);
         w.addr = 8'h41; w.data = 8'hC3;
         exp_wq.push_back(w);
         ref_mem[8'h41] = 8'hC3;
         ref_ptr = 8'h42;
         write_byte(8'hC3, ack);
         check("abort_data_ack", ack, 1);
         i2c_stop();
         wait_clks(4);
         check("abort_ptr_after", regs.o_reg_addr, ref_ptr);
      end

`ifdef I2C_TARGET_GLITCH_FILTER_EN
      // Short SCL pulse inside a low phase must not clock a bit
      i2c_start();
      write_byte({DEV, I2C_WR}, ack);
      write_byte(8'h30, ack);
      ref_ptr = 8'h30;
      wait_clks(Q);
      scl_m = 1'b1; wait_clks(2); scl_m = 1'b0;
      begin
         wr_t w;
         w.addr = 8'h30; w.data = 8'h9D;
         exp_wq.push_back(w);
         ref_mem[8'h30] = 8'h9D;
         ref_ptr = 8'h31;
         write_byte(8'h9D, ack);
         check("glitch_data_ack", ack, 1);
      end
      i2c_stop();
      wait_clks(4);
      check("glitch_ptr_after", regs.o_reg_addr, ref_ptr);
`endif

      // Randomized transactions
      for (int t = 0; t < 8; t++) begin
         int n;
         n = int'($urandom_range(1, 4));
         if ($urandom_range(0, 1) == 0) begin
            q = {};
            for (int k = 0; k < n; k++) q.push_back(8'($urandom));
            tx_write(8'($urandom), q);
         end else begin
            tx_read(1'($urandom_range(0, 1)), 8'($urandom), n);
         end
      end

      // Reset asserted while the target drives ACK
      i2c_start();
      for (int i = 7; i >= 0; i--) begin
         logic [7:0] ab;
         ab = {DEV, I2C_WR};
         bit_xfer(ab[i], line);
      end
      wait_clks(Q); sda_m = 1'b1;
      wait_clks(Q); scl_m = 1'b1;
      wait_clks(Q);
      check("ack_before_reset", sda_oe, 1);
      reset = 1'b1;
      #1;
      check("sda_oe_async_reset", sda_oe, 0);
      wait_clks(3);
      check("reset_busy", o_busy, 0);
      check("reset_addr", regs.o_reg_addr, 0);
      reset = 1'b0;
      model_reset();
      wait_clks(Q); scl_m = 1'b0;
      i2c_stop();
      tx_read(1'b0, 8'h00, 2);

      wait_clks(20);
      check("wq_drained", exp_wq.size(), 0);
      check("rq_drained", exp_rq.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
